// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO between a producer and a consumer sharing one clock.
// Up to DEPTH words of WIDTH bits live in a circular RAM. A read pointer and
// a write pointer index that RAM. A separate occupancy counter tells full
// and empty apart, so DEPTH does not have to be a power of two and the
// pointers carry no extra wrap bit.
//
// Ports
//   clk           in   rising-edge clock for all state
//   reset         in   asynchronous, active-low reset
//   write_en      in   write request this cycle
//   write_data    in   word stored when the write is accepted
//   read_en       in   read request this cycle
//   read_data     out  registered read data, valid one cycle after the read
//   full          out  count == DEPTH
//   almost_full   out  count >= AF_LEVEL
//   empty         out  count == 0
//   almost_empty  out  count <= AE_LEVEL
//   count         out  current occupancy
//   overflow      out  (FIFO_ERR_FLAGS_EN only) sticky, write_en while full
//   underflow     out  (FIFO_ERR_FLAGS_EN only) sticky, read_en while empty
//
// Build option
//   FIFO_ERR_FLAGS_EN  define to add the sticky overflow/underflow outputs.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_en,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         read_en,
    output logic [WIDTH-1:0]             read_data,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic                         almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
`else
    output logic [$clog2(DEPTH+1)-1:0]   count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    // Storage is not reset. Entries become meaningful only once written.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] read_data_q, read_data_d;

    logic             wr_accept;
    logic             rd_accept;

    // Status flags decode the registered count, so they change on the same
    // cycle as count.
    always_comb begin
        full         = (count_q == FULL_CNT);
        almost_full  = (count_q >= AF_CNT);
        empty        = (count_q == '0);
        almost_empty = (count_q <= AE_CNT);
    end

    // Acceptance is gated by the current flags. A write into an empty FIFO
    // is never forwarded to read_data in the same cycle: the read is
    // refused because empty is still set.
    always_comb begin
        wr_accept = write_en & ~full;
        rd_accept = read_en & ~empty;
    end

    // Next-state logic. Pointers wrap by index at DEPTH-1.
    // The count moves only when exactly one side is accepted.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        read_data_d = read_data_q;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
        end

        if (rd_accept) begin
            rd_ptr_d    = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
            read_data_d = mem[rd_ptr_q];
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register. An asserted reset drops all stored entries
    // at once by clearing the pointers and the occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
        end
    end

    // RAM write port. It has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= write_data;
        end
    end

    assign read_data = read_data_q;
    assign count     = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags record the raw request, not the accepted one.
    // Only reset clears them.
    always_comb begin
        overflow_d  = overflow_q | (write_en & full);
        underflow_d = underflow_q | (read_en & empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//
// Drives sync_fifo with directed sequences and randomized traffic.
// Every cycle the outputs are compared against a queue-based model of the
// FIFO. Acceptance, ordering and flag thresholds come from the occupancy
// rules. Inputs change on the falling edge. Outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DEPTH    = 32;
    localparam int WIDTH    = 8;
    localparam int AF_LEVEL = 28;
    localparam int AE_LEVEL = 4;
    localparam int CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: the queue holds the stored words, oldest first.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_rd;
    bit               model_ovf;
    bit               model_unf;

    sync_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_en      (read_en),
        .read_data    (read_data),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`else
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_rd  = '0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    // Expected flags follow directly from the model occupancy.
    task automatic checkOutput(input string ctx);
        int occ;
        occ = model_q.size();
        checkValue({ctx, ":count"},        32'(count),        32'(occ));
        checkValue({ctx, ":full"},         32'(full),         32'(occ == DEPTH));
        checkValue({ctx, ":almost_full"},  32'(almost_full),  32'(occ >= AF_LEVEL));
        checkValue({ctx, ":empty"},        32'(empty),        32'(occ == 0));
        checkValue({ctx, ":almost_empty"}, 32'(almost_empty), 32'(occ <= AE_LEVEL));
        checkValue({ctx, ":read_data"},    32'(read_data),    32'(model_rd));
`ifdef FIFO_ERR_FLAGS_EN
        checkValue({ctx, ":overflow"},     32'(overflow),     32'(model_ovf));
        checkValue({ctx, ":underflow"},    32'(underflow),    32'(model_unf));
`endif
    endtask

    // One clock cycle of traffic. The model decides acceptance from the
    // occupancy before the edge. It pops before it pushes, so a word written
    // into an empty FIFO cannot be read out in the same cycle.
    task automatic applyStimulus(input string ctx, input logic we, input logic re,
                                 input logic [WIDTH-1:0] data);
        bit wr_ok;
        bit rd_ok;
        @(negedge clk);
        write_en   = we;
        read_en    = re;
        write_data = data;
        wr_ok = we && (model_q.size() < DEPTH);
        rd_ok = re && (model_q.size() != 0);
        if (we && model_q.size() == DEPTH) model_ovf = 1'b1;
        if (re && model_q.size() == 0)     model_unf = 1'b1;
        @(posedge clk);
        if (rd_ok) model_rd = model_q.pop_front();
        if (wr_ok) model_q.push_back(data);
        #1;
        checkOutput(ctx);
    endtask

    // Assert reset between clock edges and check the cleared state while
    // reset is still low, then release it on a falling edge.
    task automatic pulseReset(input string ctx);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput(ctx);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d;

        // Reset is held low for 12 ns from time zero.
        reset      = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = '0;
        modelReset();
        #11;
        checkOutput("reset");
        #1;
        reset = 1'b1;
        $display("[TB] reset released");

        // Write 0x01..0x05, then read the five words back in order.
        for (int i = 1; i <= 5; i++) applyStimulus("basic_wr", 1'b1, 1'b0, WIDTH'(i));
        for (int i = 0; i < 5; i++)  applyStimulus("basic_rd", 1'b0, 1'b1, '0);
        checkValue("basic:last_word", 32'(read_data), 32'h05);

        // Write 0x11..0x31 (33 words). The last write arrives while full and is dropped.
        for (int i = 0; i <= DEPTH; i++) applyStimulus("overflow_wr", 1'b1, 1'b0, WIDTH'(8'h11 + i));
        checkValue("overflow:count_held", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)  applyStimulus("overflow_drain", 1'b0, 1'b1, '0);
        checkValue("overflow:last_kept", 32'(read_data), 32'h30);

        // Read an empty FIFO straight after reset.
        pulseReset("underflow_reset");
        for (int i = 0; i < 5; i++) applyStimulus("underflow_rd", 1'b0, 1'b1, '0);

        // Fill to 16, then read and write together across the pointer wrap.
        pulseReset("wrap_reset");
        for (int i = 0; i < 16; i++) applyStimulus("wrap_fill", 1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 40; i++) applyStimulus("wrap_rw", 1'b1, 1'b1, WIDTH'($urandom));
        checkValue("wrap:count_16", 32'(count), 32'd16);

        // Random traffic biased toward filling, then toward draining, so
        // both boundaries are reached repeatedly.
        for (int i = 0; i < 300; i++) begin
            d = WIDTH'($urandom);
            applyStimulus("rand_fill", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), d);
        end
        for (int i = 0; i < 300; i++) begin
            d = WIDTH'($urandom);
            applyStimulus("rand_drain", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), d);
        end

        // Reset in the middle of operation with 10 words stored.
        pulseReset("midop_reset0");
        for (int i = 0; i < 10; i++) applyStimulus("midop_fill", 1'b1, 1'b0, WIDTH'($urandom));
        pulseReset("midop_reset");
        applyStimulus("midop_wr", 1'b1, 1'b0, 8'hA5);
        applyStimulus("midop_rd", 1'b0, 1'b1, '0);
        checkValue("midop:new_data", 32'(read_data), 32'hA5);
        applyStimulus("midop_idle", 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
